// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel divider, h/v counters, syncs, strobes and frame-latched 1x/2x coordinates.
// Optional raster-line interrupt is compiled in with `define VIDEO_TIMING_LINE_IRQ_EN.
module video_timing_gen #(
  parameter int H_ACTIVE     = 320,
  parameter int V_ACTIVE     = 240,
  parameter int H_BLANK      = 80,
  parameter int V_BLANK      = 80,
  parameter int H_SYNC_START = 336,
  parameter int H_SYNC_LEN   = 32,
  parameter int V_SYNC_START = 250,
  parameter int V_SYNC_LEN   = 4,
  parameter int SYNC_POL     = 0,
  parameter int PIX_DIV      = 2,
  parameter int CNT_W        = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             scale,
  input  logic [CNT_W-1:0] line_cmp,
  output logic             pix_ce,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start,
  output logic             line_start,
  output logic             vblank_start,
  output logic             line_irq
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);

  // Sync window ends may equal the total, so compare one bit wider.
  localparam logic [CNT_W:0] H_SS = (CNT_W+1)'(H_SYNC_START);
  localparam logic [CNT_W:0] H_SE = (CNT_W+1)'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [CNT_W:0] V_SS = (CNT_W+1)'(V_SYNC_START);
  localparam logic [CNT_W:0] V_SE = (CNT_W+1)'(V_SYNC_START + V_SYNC_LEN);

  localparam logic SYNC_ACT = (SYNC_POL != 0);

  logic [DIV_W-1:0] div;
  logic             en_q;
  logic             scale_q;
  logic             h_in_sync;
  logic             v_in_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div     <= '0;
      en_q    <= 1'b0;
      scale_q <= 1'b0;
      hcnt    <= '0;
      vcnt    <= '0;
    end else begin
      en_q <= en;
      if (frame_start) begin
        scale_q <= scale;
      end
      if (!en) begin
        div  <= '0;
        hcnt <= '0;
        vcnt <= '0;
      end else begin
        // The divider starts one clk after en_q rises so a restart begins at div=0.
        if (en_q) begin
          div <= (div == DIV_LAST) ? '0 : div + 1'b1;
        end
        if (pix_ce) begin
          if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
      end
    end
  end

  assign pix_ce = en && en_q && (div == DIV_LAST);

  assign de = en_q && (hcnt < H_ACT) && (vcnt < V_ACT);

  assign h_in_sync = ({1'b0, hcnt} >= H_SS) && ({1'b0, hcnt} < H_SE);
  assign v_in_sync = ({1'b0, vcnt} >= V_SS) && ({1'b0, vcnt} < V_SE);
  assign hsync     = h_in_sync ? SYNC_ACT : !SYNC_ACT;
  assign vsync     = v_in_sync ? SYNC_ACT : !SYNC_ACT;

  assign line_start   = pix_ce && (hcnt == '0);
  assign frame_start  = line_start && (vcnt == '0);
  assign vblank_start = line_start && (vcnt == V_ACT);

  assign x = scale_q ? (hcnt >> 1) : hcnt;
  assign y = scale_q ? (vcnt >> 1) : vcnt;

`ifdef VIDEO_TIMING_LINE_IRQ_EN
  // Fires at the start of hblank on the compared line; out-of-range compares never match.
  assign line_irq = pix_ce && (hcnt == H_ACT) && (vcnt == line_cmp);
`else
  logic unused_line_cmp;
  assign unused_line_cmp = ^line_cmp;
  assign line_irq        = 1'b0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised scoreboard bench for video_timing_gen on a reduced raster geometry.
`timescale 1ns/1ps
module tb_video_timing_gen;

  localparam int HA  = 12;
  localparam int HB  = 6;
  localparam int VA  = 8;
  localparam int VB  = 5;
  localparam int HSS = 13;
  localparam int HSL = 3;
  localparam int VSS = 9;
  localparam int VSL = 2;
  localparam int POL = 0;
  localparam int PD  = 2;
  localparam int CW  = 5;
  localparam int HT  = HA + HB;
  localparam int VT  = VA + VB;
  localparam int N_CYC = 9000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          scale;
  logic [CW-1:0] line_cmp;
  logic          pix_ce;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          de;
  logic          hsync;
  logic          vsync;
  logic          frame_start;
  logic          line_start;
  logic          vblank_start;
  logic          line_irq;

  video_timing_gen #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB),
    .H_SYNC_START(HSS), .H_SYNC_LEN(HSL), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL),
    .SYNC_POL(POL), .PIX_DIV(PD), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .scale(scale), .line_cmp(line_cmp),
    .pix_ce(pix_ce), .hcnt(hcnt), .vcnt(vcnt), .x(x), .y(y), .de(de),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start),
    .line_start(line_start), .vblank_start(vblank_start), .line_irq(line_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit pix, de, hs, vs, fs, ls, vb, irq;
    int h, v, x, y;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   armed = 0;

  // Reference state: pixels emitted and running clks since the last (re)start.
  bit m_enq;
  int m_k;
  int m_p;
  bit m_scale;
  int en_off;

  task automatic model_edge();
    if (!rst_n) begin
      m_enq = 0; m_k = 0; m_p = 0; m_scale = 0;
    end else begin
      if (last_e.fs) m_scale = scale;
      if (last_e.pix) m_p++;
      if (!en) begin
        m_k = 0; m_p = 0;
      end else if (m_enq) begin
        m_k++;
      end
      m_enq = en;
    end
  endtask

  function automatic exp_t predict(int c);
    exp_t e;
    int h, v;
    h = m_p % HT;
    v = (m_p / HT) % VT;
    e.cyc = c;
    e.h   = h;
    e.v   = v;
    e.x   = m_scale ? h / 2 : h;
    e.y   = m_scale ? v / 2 : v;
    e.pix = en && m_enq && ((m_k % PD) == PD - 1);
    e.de  = m_enq && (h < HA) && (v < VA);
    e.hs  = (h >= HSS && h < HSS + HSL) ? (POL != 0) : (POL == 0);
    e.vs  = (v >= VSS && v < VSS + VSL) ? (POL != 0) : (POL == 0);
    e.ls  = e.pix && (h == 0);
    e.fs  = e.ls && (v == 0);
    e.vb  = e.ls && (v == VA);
`ifdef VIDEO_TIMING_LINE_IRQ_EN
    e.irq = e.pix && (h == HA) && (v == int'(line_cmp));
`else
    e.irq = 1'b0;
`endif
    return e;
  endfunction

  task automatic drive(int c);
    rst_n = !(c < 5 || (c >= 4000 && c < 4003));
    if (c < 15) begin
      en = 0;
    end else if (en_off > 0) begin
      en = 0;
      en_off--;
    end else if ($urandom_range(0, 699) == 0) begin
      en = 0;
      en_off = $urandom_range(0, 4);
    end else begin
      en = 1;
    end
    if ($urandom_range(0, 149) == 0) scale = !scale;
    if ($urandom_range(0, 59) == 0)
      line_cmp = ($urandom_range(0, 2) == 0) ? CW'(VA - 1) : CW'($urandom_range(0, 2 ** CW - 1));
  endtask

  task automatic check(exp_t e);
    logic [7:0] act, exq;
    act = {pix_ce, de, hsync, vsync, frame_start, line_start, vblank_start, line_irq};
    exq = {e.pix, e.de, e.hs, e.vs, e.fs, e.ls, e.vb, e.irq};
    n_cmp++;
    if (act !== exq) begin
      n_bad++;
      $display("FAIL flags cyc=%0d {pix,de,hs,vs,fs,ls,vb,irq} got=%b want=%b", e.cyc, act, exq);
    end
    n_cmp++;
    if (hcnt !== CW'(e.h) || vcnt !== CW'(e.v)) begin
      n_bad++;
      $display("FAIL counters cyc=%0d got h=%0d v=%0d want h=%0d v=%0d", e.cyc, hcnt, vcnt, e.h, e.v);
    end
    if (e.de) begin
      n_cmp++;
      if (x !== CW'(e.x) || y !== CW'(e.y)) begin
        n_bad++;
        $display("FAIL coords cyc=%0d got x=%0d y=%0d want x=%0d y=%0d", e.cyc, x, y, e.x, e.y);
      end
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (armed) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_underflow got=empty want=entry");
        end else begin
          e = sb.pop_front();
          check(e);
        end
      end
    end
  end

  initial begin
    rst_n = 0; en = 0; scale = 0; line_cmp = '0;
    en_off = 0;
    last_e = '{default: 0};
    m_enq = 0; m_k = 0; m_p = 0; m_scale = 0;
    for (int c = 0; c < N_CYC; c++) begin
      @(posedge clk);
      model_edge();
      #2;
      drive(c);
      last_e = predict(c);
      sb.push_back(last_e);
      armed = 1;
    end
    @(posedge clk);
    #2;
    armed = 0;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain got=%0d want=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator driving the sprite/map/tile/palette render pipeline and the display output.
- Produces pixel clock-enable, horizontal/vertical counters, display-enable, syncs, frame/line/vblank strobes and scaled logical coordinates.
- Supersedes the fixed 320x240 timing constants with fully parametrised geometry, a pixel-clock divider, a runtime 1x/2x scale mode latched at frame boundaries, and a raster-line interrupt.

Parameters:
- H_ACTIVE, 320, visible pixels per line
- V_ACTIVE, 240, visible lines per frame
- H_BLANK, 80, blank pixels per line; H_TOTAL = H_ACTIVE + H_BLANK = 400
- V_BLANK, 80, blank lines per frame; V_TOTAL = V_ACTIVE + V_BLANK = 320
- H_SYNC_START, 336, first hcnt with hsync active; must satisfy H_ACTIVE <= H_SYNC_START < H_TOTAL
- H_SYNC_LEN, 32, hsync width in pixels; H_SYNC_START + H_SYNC_LEN <= H_TOTAL
- V_SYNC_START, 250, first vcnt with vsync active; must satisfy V_ACTIVE <= V_SYNC_START < V_TOTAL
- V_SYNC_LEN, 4, vsync width in lines; V_SYNC_START + V_SYNC_LEN <= V_TOTAL
- SYNC_POL, 0, active sync level; 0 = active-low
- PIX_DIV, 2, clk cycles per pixel; valid range >= 1
- CNT_W, 10, counter and coordinate width; 2^CNT_W must be >= max(H_TOTAL, V_TOTAL)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  run enable
- scale  in  1  0 = 1x, 1 = 2x (x, y = counters >> 1); latched at frame start
- line_cmp  in  CNT_W  raster compare line
- pix_ce  out  1  one-clk pixel strobe
- hcnt  out  CNT_W  horizontal counter
- vcnt  out  CNT_W  vertical counter
- x  out  CNT_W  logical x coordinate
- y  out  CNT_W  logical y coordinate
- de  out  1  display enable
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- frame_start  out  1  frame-start strobe
- line_start  out  1  line-start strobe
- vblank_start  out  1  vblank-start strobe
- line_irq  out  1  raster-line interrupt strobe

Behaviour:
- Reset (rst_n=0 at a clk edge), registered values:
  - div, hcnt, vcnt, x, y, scale_q = 0.
  - pix_ce, de and all strobes = 0.
  - hsync, vsync = !SYNC_POL.
- Divider:
  - div counts 0..PIX_DIV-1 while en=1.
  - pix_ce=1 exactly on clks where div == PIX_DIV-1; with PIX_DIV=1, pix_ce=1 on every running clk.
- Counter advance (on pix_ce only):
  - hcnt increments; at H_TOTAL-1 it wraps to 0 and vcnt increments.
  - vcnt wraps from V_TOTAL-1 to 0.
  - Counters hold between pix_ce pulses.
- Combinational outputs, functions of the registered counters with zero added latency:
  - de = en_q && hcnt < H_ACTIVE && vcnt < V_ACTIVE.
  - hsync = SYNC_POL when hcnt is in [H_SYNC_START, H_SYNC_START+H_SYNC_LEN), else !SYNC_POL.
  - vsync: same rule using vcnt and the V_SYNC parameters.
- Strobes (each a single clk, coincident with pix_ce):
  - line_start when hcnt==0.
  - frame_start when hcnt==0 && vcnt==0.
  - vblank_start when hcnt==0 && vcnt==V_ACTIVE.
- Scale mode:
  - scale_q <= scale on the clk frame_start fires; a scale change mid-frame has no effect until the next frame.
  - x = hcnt >> scale_q; y = vcnt >> scale_q.
  - x and y are meaningful only while de=1.
- en handling:
  - en_q is en registered.
  - On en=0: div, hcnt, vcnt clear to 0 on the next clk; pix_ce, de and strobes are 0; syncs are inactive.
  - On re-assert: counting restarts at (0,0) with div=0; the first frame_start comes PIX_DIV clks after en_q rises.
- Simultaneous events: at hcnt=H_TOTAL-1, vcnt=V_TOTAL-1, pix_ce wraps both counters in one clk. The next pixel's strobes (frame_start and line_start) fire together.
- Reset mid-frame: takes effect immediately, same as power-up reset.

Optional Feature:
- Macro: VIDEO_TIMING_LINE_IRQ_EN.
- Defined: line_irq pulses for one clk when pix_ce && hcnt==H_ACTIVE && vcnt==line_cmp.
  - This is the start of hblank on the compared line.
  - line_cmp is sampled in that same clk.
  - line_cmp >= V_TOTAL never fires.
- Undefined: line_irq tied to 0; line_cmp unused.

Test Plan:
- Reset/idle: hold rst_n=0 for 5 clks, then en=0 for 10 clks -> hcnt=vcnt=0, de=0, hsync=vsync=1 (SYNC_POL=0), no strobes.
- Frame period: defaults, en=1 -> successive frame_start strobes exactly 256000 clks apart; line_start 800 clks apart; vblank_start 192000 clks after frame_start.
- Sync/DE windows: defaults -> hsync low for hcnt 336..367 (64 clks); vsync low for vcnt 250..253; de high for exactly 76800 pix_ce per frame.
- Scale latch: toggle scale 0->1 at vcnt=100 -> x continues to equal hcnt for the rest of that frame; after the next frame_start, hcnt=301 gives x=150 and vcnt=201 gives y=100.
- en restart: deassert en at hcnt=57, vcnt=33 -> counters read 0 the next clk; re-assert -> frame_start fires 2 clks after en_q rises.
- Line IRQ (macro defined): line_cmp=239 -> a single line_irq per frame at vcnt=239, hcnt=320; line_cmp=400 -> no line_irq; macro undefined -> line_irq stays 0.
